nic_host_sequencer: RTL and testbench

//  Processor-side controller for one ring NIC. Owns the NIC register port (addr/d_in/d_out/nicEn/nicWrEn).

---
 rtl/nic_host_sequencer.sv | 135 +++++++++++++
 tb/tb_nic_host_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_host_sequencer.sv
// Processor-side sequencer for one ring NIC: polls NIC status and moves words between local
// TX/RX queues and the NIC buffers over a single shared register port, round-robin between sides.
module nic_host_sequencer #(
   parameter int TX_DEPTH   = 4,
   parameter int RX_DEPTH   = 4,
   parameter int STATUS_BIT = 63
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [0:63] tx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [0:63] rx_data,
   output logic [0:1]  nic_addr,
   output logic [0:63] nic_d_in,
   input  logic [0:63] nic_d_out,
   output logic        nic_en,
   output logic        nic_wr_en,
   output logic        busy
);

   localparam int DATA_W = 64;
   localparam int TXA    = $clog2(TX_DEPTH);
   localparam int RXA    = $clog2(RX_DEPTH);
   localparam logic [TXA:0] TX_FULL_CNT = (TXA+1)'(TX_DEPTH);
   localparam logic [RXA:0] RX_FULL_CNT = (RXA+1)'(RX_DEPTH);
   localparam logic RR_TX = 1'b0;
   localparam logic RR_RX = 1'b1;

   typedef enum logic [2:0] {
      IDLE, RX_STAT, RX_CHK, RX_RD, RX_CAP, TX_STAT, TX_CHK, TX_WR
   } state_t;

   state_t state;
   logic   rr_last;

   logic [0:DATA_W-1] tx_mem [TX_DEPTH];
   logic [0:DATA_W-1] rx_mem [RX_DEPTH];
   logic [TXA-1:0]    tx_wr_ptr, tx_rd_ptr;
   logic [RXA-1:0]    rx_wr_ptr, rx_rd_ptr;
   logic [TXA:0]      tx_count;
   logic [RXA:0]      rx_count;

   logic tx_push, tx_pop, rx_push, rx_pop;
   logic tx_ok, rx_ok;

   assign tx_ok   = (tx_count != '0);
   assign rx_ok   = (rx_count < RX_FULL_CNT);
   assign tx_push = tx_valid & tx_ready;
   assign tx_pop  = ~reset & (state == TX_WR);
   // RX_CAP only happens after IDLE saw a free slot; the PE can only free more
   assign rx_push = ~reset & (state == RX_CAP);
   assign rx_pop  = rx_valid & rx_ready;

   // Moore decodes, forced quiet while reset is held
   assign tx_ready  = ~reset & (tx_count != TX_FULL_CNT);
   assign rx_valid  = ~reset & (rx_count != '0);
   assign rx_data   = rx_mem[rx_rd_ptr];
   assign busy      = ~reset & (state != IDLE);
   assign nic_en    = ~reset & ((state == RX_STAT) | (state == RX_RD) |
                                (state == TX_STAT) | (state == TX_WR));
   assign nic_wr_en = ~reset & (state == TX_WR);
   assign nic_d_in  = (~reset && state == TX_WR) ? tx_mem[tx_rd_ptr] : '0;

   always_comb begin
      nic_addr = 2'b00;
      if (!reset) begin
         case (state)
            RX_STAT: nic_addr = 2'b01;
            TX_STAT: nic_addr = 2'b11;
            TX_WR:   nic_addr = 2'b10;
            default: nic_addr = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
      if (rx_push) rx_mem[rx_wr_ptr] <= nic_d_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TXA'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TXA'(1);
         if (tx_push && !tx_pop)      tx_count <= tx_count + (TXA+1)'(1);
         else if (!tx_push && tx_pop) tx_count <= tx_count - (TXA+1)'(1);
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RXA'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RXA'(1);
         if (rx_push && !rx_pop)      rx_count <= rx_count + (RXA+1)'(1);
         else if (!rx_push && rx_pop) rx_count <= rx_count - (RXA+1)'(1);
      end
   end

   // Status reads return data one cycle later, so each *_CHK state samples nic_d_out
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rr_last <= RR_TX;
      end else begin
         case (state)
            IDLE: begin
               if (rx_ok && tx_ok) state <= (rr_last == RR_RX) ? TX_STAT : RX_STAT;
               else if (rx_ok)     state <= RX_STAT;
               else if (tx_ok)     state <= TX_STAT;
               else                state <= IDLE;
            end
            RX_STAT: state <= RX_CHK;
            RX_CHK: begin
               rr_last <= RR_RX;
               state   <= nic_d_out[STATUS_BIT] ? RX_RD : IDLE;
            end
            RX_RD:   state <= RX_CAP;
            RX_CAP:  state <= IDLE;
            TX_STAT: state <= TX_CHK;
            TX_CHK: begin
               rr_last <= RR_TX;
               state   <= nic_d_out[STATUS_BIT] ? IDLE : TX_WR;
            end
            TX_WR:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nic_host_sequencer.sv
// Directed bench for nic_host_sequencer: cycle table for reset/send, then hand sequences
// for busy out-buffer, receive, RX back-pressure and round-robin fairness.
module tb_nic_host_sequencer;

   localparam int STATUS_BIT = 63;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [0:63] tx_data = '0;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic [0:63] rx_data;
   logic [0:1]  nic_addr;
   logic [0:63] nic_d_in;
   logic [0:63] nic_d_out = '0;
   logic        nic_en;
   logic        nic_wr_en;
   logic        busy;

   int checks = 0;
   int failures = 0;

   nic_host_sequencer #(.TX_DEPTH(4), .RX_DEPTH(4), .STATUS_BIT(STATUS_BIT)) dut (
      .clk(clk), .reset(reset),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
      .nic_en(nic_en), .nic_wr_en(nic_wr_en), .busy(busy)
   );

   always #5 clk = ~clk;

   // NIC register model
   logic [0:63] in_q [$];
   logic [0:63] out_log [$];
   logic [1:0]  stat_log [$];
   int          ostat_busy_left = 0;
   int          ostat_reads = 0, istat_reads = 0, ibuf_reads = 0;
   logic [2:0]  last_acc = '0, ibuf_prev = '0;

   function automatic logic [0:63] status_word(input logic flag);
      logic [0:63] w;
      w = '0;
      w[STATUS_BIT] = flag;
      return w;
   endfunction

   always @(posedge clk) begin
      if (nic_en) begin
         last_acc <= {nic_wr_en, nic_addr};
         if (nic_wr_en) begin
            if (nic_addr == 2'b10) out_log.push_back(nic_d_in);
         end else begin
            case (nic_addr)
               2'b00: begin
                  ibuf_prev  <= last_acc;
                  ibuf_reads <= ibuf_reads + 1;
                  nic_d_out  <= (in_q.size() != 0) ? in_q.pop_front() : '0;
               end
               2'b01: begin
                  istat_reads <= istat_reads + 1;
                  stat_log.push_back(2'b01);
                  nic_d_out <= status_word(in_q.size() != 0);
               end
               2'b11: begin
                  ostat_reads <= ostat_reads + 1;
                  stat_log.push_back(2'b11);
                  nic_d_out <= status_word(ostat_busy_left != 0);
                  if (ostat_busy_left > 0) ostat_busy_left <= ostat_busy_left - 1;
               end
               default: nic_d_out <= '0;
            endcase
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_tx(input logic [0:63] d);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic pop_rx();
      @(negedge clk);
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int k = 0;
      while (out_log.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   typedef struct {
      logic        rst;
      logic        tv;
      logic [63:0] td;
      logic        en;
      logic        wr;
      logic [1:0]  addr;
      logic        trdy;
      logic        bsy;
      logic [63:0] din;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int base, base_r, k;
      logic [63:0] got;

      //          rst tv  td      en wr addr  trdy bsy din
      vecs[0]  = '{1, 1, 64'h11,  0, 0, 2'b00, 0, 0, 64'h0};
      vecs[1]  = '{1, 1, 64'h11,  0, 0, 2'b00, 0, 0, 64'h0};
      vecs[2]  = '{0, 0, 64'h0,   0, 0, 2'b00, 1, 0, 64'h0};
      vecs[3]  = '{0, 0, 64'h0,   1, 0, 2'b01, 1, 1, 64'h0};
      vecs[4]  = '{0, 0, 64'h0,   0, 0, 2'b00, 1, 1, 64'h0};
      vecs[5]  = '{0, 1, 64'hA5,  0, 0, 2'b00, 1, 0, 64'h0};
      vecs[6]  = '{0, 0, 64'h0,   1, 0, 2'b01, 1, 1, 64'h0};
      vecs[7]  = '{0, 0, 64'h0,   0, 0, 2'b00, 1, 1, 64'h0};
      vecs[8]  = '{0, 0, 64'h0,   0, 0, 2'b00, 1, 0, 64'h0};
      vecs[9]  = '{0, 0, 64'h0,   1, 0, 2'b11, 1, 1, 64'h0};
      vecs[10] = '{0, 0, 64'h0,   0, 0, 2'b00, 1, 1, 64'h0};
      vecs[11] = '{0, 0, 64'h0,   1, 1, 2'b10, 1, 1, 64'hA5};
      vecs[12] = '{0, 0, 64'h0,   0, 0, 2'b00, 1, 0, 64'h0};
      vecs[13] = '{0, 0, 64'h0,   1, 0, 2'b01, 1, 1, 64'h0};

      // reset with tx_valid held, then one word sent through the round-robin
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         reset    = vecs[i].rst;
         tx_valid = vecs[i].tv;
         tx_data  = vecs[i].td;
         #1;
         chk($sformatf("v%0d_nic_en", i), 64'(nic_en), 64'(vecs[i].en));
         chk($sformatf("v%0d_nic_wr_en", i), 64'(nic_wr_en), 64'(vecs[i].wr));
         chk($sformatf("v%0d_nic_addr", i), 64'(nic_addr), 64'(vecs[i].addr));
         chk($sformatf("v%0d_tx_ready", i), 64'(tx_ready), 64'(vecs[i].trdy));
         chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
         chk($sformatf("v%0d_nic_d_in", i), nic_d_in, vecs[i].din);
      end
      tx_valid = 1'b0;
      chk("t2_single_write", 64'(out_log.size()), 64'd1);

      // out-buffer reports full for three polls
      ostat_busy_left = 3;
      base   = out_log.size();
      base_r = ostat_reads;
      push_tx(64'hA5);
      repeat (8) @(negedge clk);
      chk("t3_held_no_write", 64'(out_log.size()), 64'(base));
      wait_writes(base + 1, 100);
      chk("t3_write_count", 64'(out_log.size()), 64'(base + 1));
      got = (out_log.size() > base) ? out_log[base] : '0;
      chk("t3_write_data", got, 64'hA5);
      chk("t3_status_polls", 64'(ostat_reads - base_r), 64'd4);

      // receive one word
      base = ibuf_reads;
      in_q.push_back(64'h1234);
      k = 0;
      while (!rx_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("t4_rx_valid", 64'(rx_valid), 64'd1);
      chk("t4_rx_data", rx_data, 64'h1234);
      chk("t4_inbuf_reads", 64'(ibuf_reads - base), 64'd1);
      chk("t4_status_before_read", 64'(ibuf_prev), 64'b001);
      pop_rx();
      @(negedge clk);
      chk("t4_rx_empty_after_pop", 64'(rx_valid), 64'd0);

      // RX back-pressure: fill the RX queue, polling must stop, TX still served
      for (int j = 0; j < 4; j++) in_q.push_back(64'hB0 + 64'(j));
      k = 0;
      while (in_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      repeat (10) @(negedge clk);
      chk("t5_inq_drained", 64'(in_q.size()), 64'd0);
      chk("t5_idle_when_full", 64'(busy), 64'd0);
      base_r = istat_reads;
      repeat (20) @(negedge clk);
      chk("t5_no_rx_polls", 64'(istat_reads - base_r), 64'd0);
      base = out_log.size();
      push_tx(64'h77);
      wait_writes(base + 1, 50);
      got = (out_log.size() > base) ? out_log[base] : '0;
      chk("t5_tx_served", got, 64'h77);
      chk("t5_still_no_rx_polls", 64'(istat_reads - base_r), 64'd0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk($sformatf("t5_rx_valid_%0d", j), 64'(rx_valid), 64'd1);
         chk($sformatf("t5_rx_data_%0d", j), rx_data, 64'hB0 + 64'(j));
         pop_rx();
      end
      repeat (10) @(negedge clk);
      chk("t5_polls_resume", 64'(istat_reads > base_r), 64'd1);

      // fairness: TX blocked by a permanently full out-buffer, RX always has data
      ostat_busy_left = -1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk($sformatf("t6_ready_before_%0d", j), 64'(tx_ready), 64'd1);
         push_tx(64'hC0 + 64'(j));
      end
      @(negedge clk);
      chk("t6_tx_full", 64'(tx_ready), 64'd0);
      tx_valid = 1'b1;
      tx_data  = 64'h55;
      repeat (3) @(negedge clk);
      tx_valid = 1'b0;
      chk("t6_still_full", 64'(tx_ready), 64'd0);
      rx_ready = 1'b1;
      for (int j = 0; j < 12; j++) in_q.push_back(64'hD0 + 64'(j));
      stat_log.delete();
      k = 0;
      while (stat_log.size() < 8 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t6_poll_count", 64'(stat_log.size() >= 8), 64'd1);
      for (int j = 1; j < 8; j++) begin
         got = (stat_log.size() > j) ? 64'(stat_log[j] != stat_log[j-1]) : '0;
         chk($sformatf("t6_alternate_%0d", j), got, 64'd1);
      end
      base = out_log.size();
      ostat_busy_left = 0;
      wait_writes(base + 4, 300);
      for (int j = 0; j < 4; j++) begin
         got = (out_log.size() > base + j) ? out_log[base + j] : '0;
         chk($sformatf("t6_write_%0d", j), got, 64'hC0 + 64'(j));
      end
      repeat (30) @(negedge clk);
      chk("t6_no_overwrite_write", 64'(out_log.size()), 64'(base + 4));
      chk("t6_tx_ready_after", 64'(tx_ready), 64'd1);
      rx_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
